// File: rtl/lc3b_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_arbiter_pkg
// Description : Shared LC-3b types used by the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        arb_idle    = 2'd0,
        arb_serve_i = 2'd1,
        arb_serve_d = 2'd2
    } lc3b_arb_state;

    // Everything the memory port needs for one transaction.
    typedef struct packed {
        lc3b_word      addr;
        lc3b_word      wdata;
        lc3b_mem_wmask wmask;
        logic          write;
    } lc3b_mem_req;

    localparam lc3b_mem_req c_REQ_RESET = '0;

endpackage : lc3b_mem_arbiter_pkg
`default_nettype wire

// File: rtl/lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_arbiter
// Description : Round-robin fetch/data arbiter onto the single memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_read,
    input  logic [15:0] if_address,
    output logic [15:0] if_rdata,
    output logic        if_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_wmask,
    output logic [15:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_wmask,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp
);

    lc3b_arb_state r_state;
    lc3b_arb_state w_next_state;
    lc3b_mem_req   r_req;
    lc3b_mem_req   w_next_req;
    logic          r_last_d;
    logic          w_d_req;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_done;

    // On a tie the port that was not served last wins.
    assign w_d_req   = d_read | d_write;
    assign w_grant_d = w_d_req & (~if_read | ~r_last_d);
    assign w_grant_i = if_read & ~w_grant_d;
    assign w_done    = (r_state != arb_idle) & mem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= arb_idle;
            r_req    <= c_REQ_RESET;
            r_last_d <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_req   <= w_next_req;
            if (w_done) begin
                r_last_d <= (r_state == arb_serve_d);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_req   = r_req;
        case (r_state)
            arb_idle: begin
                if (w_grant_d) begin
                    w_next_state     = arb_serve_d;
                    w_next_req.addr  = d_address;
                    w_next_req.write = d_write;
                    // Store data only matters for writes; reads keep the old latch.
                    if (d_write) begin
                        w_next_req.wdata = d_wdata;
                        w_next_req.wmask = d_wmask;
                    end
                end else if (w_grant_i) begin
                    w_next_state     = arb_serve_i;
                    w_next_req.addr  = if_address;
                    w_next_req.write = 1'b0;
                    w_next_req.wmask = 2'b00;
                end
            end
            arb_serve_i, arb_serve_d: begin
                if (mem_resp) begin
                    w_next_state = arb_idle;
                end
            end
            default: begin
                w_next_state = arb_idle;
            end
        endcase
    end

    assign mem_read    = (r_state != arb_idle) & ~r_req.write;
    assign mem_write   = (r_state == arb_serve_d) & r_req.write;
    assign mem_address = r_req.addr;
    assign mem_wdata   = r_req.wdata;
    assign mem_wmask   = r_req.wmask;

    assign if_resp  = (r_state == arb_serve_i) & mem_resp;
    assign d_resp   = (r_state == arb_serve_d) & mem_resp;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule : lc3b_mem_arbiter
`default_nettype wire
